// File: rtl/fifo_wr_arbiter.sv
// Two-requester write arbiter onto one synchronous FIFO: one grant cycle from IDLE, bursts of up to 1<<BURST_BITS beats.
// Latency 1 cycle to grant; writes combinational while granted; fifo_full stalls the owner.
// FIFO_ARB_FIXED_PRIO_EN: req0 always wins a tie instead of round-robin.
module fifo_wr_arbiter #(
    parameter int DATA_SIZE  = 8,
    parameter int BURST_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    input  logic [DATA_SIZE-1:0] req0_data,
    input  logic [DATA_SIZE-1:0] req1_data,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic                 fifo_full,
    output logic                 fifo_we,
    output logic [DATA_SIZE-1:0] fifo_wrdata,
    output logic [1:0]           gnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [BURST_BITS-1:0] CNT_MAX = '1;

    state_t                state;
    logic [BURST_BITS-1:0] cnt;
    logic                  own_valid;
    logic                  rel;
    logic                  any_valid;
    logic                  win1;
`ifndef FIFO_ARB_FIXED_PRIO_EN
    logic                  last;
`endif

    always_comb begin
        own_valid   = ((state == GRANT0) & req0_valid) | ((state == GRANT1) & req1_valid);
        fifo_we     = own_valid & ~fifo_full;
        req0_ready  = (state == GRANT0) & ~fifo_full;
        req1_ready  = (state == GRANT1) & ~fifo_full;
        fifo_wrdata = (state == GRANT1) ? req1_data : req0_data;
        rel         = (state != IDLE) & (~own_valid | (fifo_we & (cnt == CNT_MAX)));
        any_valid   = req0_valid | req1_valid;
`ifdef FIFO_ARB_FIXED_PRIO_EN
        win1        = req1_valid & ~req0_valid;
`else
        // last=0 means req0 was served last, so req1 takes a tie
        win1        = req1_valid & (~req0_valid | ~last);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= 2'b00;
            cnt   <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last  <= 1'b1;
`endif
        end else if ((state == IDLE) || rel) begin
            // arbitrate; a re-grant to the same owner also restarts the burst
            cnt <= '0;
            if (any_valid) begin
                state <= win1 ? GRANT1 : GRANT0;
                gnt   <= win1 ? 2'b10 : 2'b01;
`ifndef FIFO_ARB_FIXED_PRIO_EN
                last  <= win1;
`endif
            end else begin
                state <= IDLE;
                gnt   <= 2'b00;
            end
        end else if (fifo_we) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter plus hand sequences for wrap and mid-burst reset.
module tb_fifo_wr_arbiter;

`ifdef FIFO_ARB_FIXED_PRIO_EN
    localparam bit FX = 1'b1;
`else
    localparam bit FX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       fifo_full;
    logic       fifo_we;
    logic [7:0] fifo_wrdata;
    logic [1:0] gnt;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(.DATA_SIZE(8), .BURST_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_data  (req0_data),
        .req1_data  (req1_data),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .fifo_full  (fifo_full),
        .fifo_we    (fifo_we),
        .fifo_wrdata(fifo_wrdata),
        .gnt        (gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v0, v1;
        logic [7:0] d0, d1;
        logic       full;
        logic [1:0] g;
        logic       we;
        logic [7:0] wd;
        logic       r0, r1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v0, input logic v1, input logic [7:0] d0,
                                input logic [7:0] d1, input logic full, input logic [1:0] g,
                                input logic we, input logic [7:0] wd, input logic r0,
                                input logic r1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.full = full;
        v.g = g; v.we = we; v.wd = wd; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] g, input logic we,
                           input logic [7:0] wd, input logic r0, input logic r1);
        chk({tag, ".gnt"}, {6'd0, gnt}, {6'd0, g});
        chk({tag, ".we"}, {7'd0, fifo_we}, {7'd0, we});
        chk({tag, ".wd"}, fifo_wrdata, wd);
        chk({tag, ".r0"}, {7'd0, req0_ready}, {7'd0, r0});
        chk({tag, ".r1"}, {7'd0, req1_ready}, {7'd0, r1});
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [7:0] d0,
                         input logic [7:0] d1, input logic full);
        @(negedge clk);
        req0_valid = v0; req1_valid = v1;
        req0_data  = d0; req1_data  = d1;
        fifo_full  = full;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        fifo_full = 1'b0;

        // both requesters streaming; req0 wins the first tie after reset
        tbl.push_back(mk(1, 1, 8'hA0, 8'hB0, 0, 2'b00, 0, 8'hA0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 8'hA0, 8'hB0, 0, 2'b01, 1, 8'hA0, 1, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 8'hA0, 8'hB0, 0, FX ? 2'b01 : 2'b10, 1,
                             FX ? 8'hA0 : 8'hB0, FX, !FX));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 8'hA0, 8'hB0, 0, 2'b01, 1, 8'hA0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, FX ? 2'b01 : 2'b10, 0, 8'h00, FX, !FX));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));
        // req0 alone writes 0x11, 0x22 then drops
        tbl.push_back(mk(1, 0, 8'h11, 8'h00, 0, 2'b00, 0, 8'h11, 0, 0));
        tbl.push_back(mk(1, 0, 8'h11, 8'h00, 0, 2'b01, 1, 8'h11, 1, 0));
        tbl.push_back(mk(1, 0, 8'h22, 8'h00, 0, 2'b01, 1, 8'h22, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'b01, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));
        // full stall after beat 2, burst finishes, immediate re-grant
        tbl.push_back(mk(1, 0, 8'hC1, 8'h00, 0, 2'b00, 0, 8'hC1, 0, 0));
        tbl.push_back(mk(1, 0, 8'hC1, 8'h00, 0, 2'b01, 1, 8'hC1, 1, 0));
        tbl.push_back(mk(1, 0, 8'hC2, 8'h00, 0, 2'b01, 1, 8'hC2, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 8'hC3, 8'h00, 1, 2'b01, 0, 8'hC3, 0, 0));
        tbl.push_back(mk(1, 0, 8'hC3, 8'h00, 0, 2'b01, 1, 8'hC3, 1, 0));
        tbl.push_back(mk(1, 0, 8'hC4, 8'h00, 0, 2'b01, 1, 8'hC4, 1, 0));
        tbl.push_back(mk(1, 0, 8'hC5, 8'h00, 0, 2'b01, 1, 8'hC5, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'b01, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));

        repeat (2) @(negedge clk);
        #1;
        chk_all("reset", 2'b00, 0, 8'h00, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].full);
            chk_all($sformatf("row%0d", i), tbl[i].g, tbl[i].we, tbl[i].wd, tbl[i].r0, tbl[i].r1);
        end

        // req1 alone for 9 words: counter wraps twice with no bubble
        begin
            int writes = 0;
            drive(0, 1, 8'h00, 8'h30, 0);
            chk_all("r1only.idle", 2'b00, 0, 8'h00, 0, 0);
            for (int i = 0; i < 9; i++) begin
                drive(0, 1, 8'h00, 8'h30 + 8'(i), 0);
                chk_all($sformatf("r1only.b%0d", i), 2'b10, 1, 8'h30 + 8'(i), 0, 1);
                if (fifo_we) writes++;
            end
            chk("r1only.writes", 8'(writes), 8'd9);
            drive(0, 0, 8'h00, 8'h00, 0);
            chk_all("r1only.drop", 2'b10, 0, 8'h00, 0, 1);
            drive(0, 0, 8'h00, 8'h00, 0);
            chk_all("r1only.idle2", 2'b00, 0, 8'h00, 0, 0);
        end

        // reset asserted during beat 3 of GRANT1, between clock edges
        drive(0, 1, 8'h00, 8'h40, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'h00, 8'h41 + 8'(i), 0);
            chk_all($sformatf("rstmid.b%0d", i), 2'b10, 1, 8'h41 + 8'(i), 0, 1);
        end
        #2 rst = 1'b0;
        #1;
        chk_all("rstmid.async", 2'b00, 0, 8'h00, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h55;
        req1_valid = 1'b1; req1_data = 8'h66;
        #1;
        chk_all("rstmid.idle", 2'b00, 0, 8'h55, 0, 0);
        drive(1, 1, 8'h55, 8'h66, 0);
        chk_all("rstmid.tie", 2'b01, 1, 8'h55, 1, 0);
        drive(0, 0, 8'h00, 8'h00, 0);
        drive(0, 0, 8'h00, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
